// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for the immediate-extension stage: decode-side input beat and ALU-side output beat.
// The master drives in_* and out_ready; the slave (the pipe) drives in_ready and out_*.
interface imm_extend_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  modport master (
    output in_valid, in_imm, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_imm, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_err
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// Registered immediate-extension stage (sign/zero/upper/branch) with a 2-entry skid buffer.
// Optional macro IMM_EXT_BRANCH_EN enables mode 11 as a sign-extended, left-shifted-by-2 offset.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  imm_extend_pipe_if.slave  pipe
);
  localparam int PAD = OUT_W - IN_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [OUT_W-1:0] out_data_q;
  logic [TAG_W-1:0] out_tag_q;
  logic             out_err_q;
  logic [OUT_W-1:0] skid_data_q;
  logic [TAG_W-1:0] skid_tag_q;
  logic             skid_err_q;

  logic             accept;
  logic             take;
  logic [OUT_W-1:0] sign_ext;
  logic [OUT_W-1:0] ext_data_d;
  logic             ext_err_d;

  assign accept = pipe.in_valid & in_ready_q;
  assign take   = out_valid_q & pipe.out_ready;

  always_comb begin
    sign_ext   = {{PAD{pipe.in_imm[IN_W-1]}}, pipe.in_imm};
    ext_data_d = sign_ext;
    ext_err_d  = 1'b0;
    case (pipe.in_mode)
      2'b00:   ext_data_d = sign_ext;
      2'b01:   ext_data_d = {{PAD{1'b0}}, pipe.in_imm};
      2'b10:   ext_data_d = {pipe.in_imm, {PAD{1'b0}}};
      default: begin
`ifdef IMM_EXT_BRANCH_EN
        // Shifting the sign-extended value drops two sign copies, so OUT_W == IN_W+2 also works.
        ext_data_d = sign_ext << 2;
`else
        ext_data_d = sign_ext;
        ext_err_d  = 1'b1;
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      out_err_q   <= 1'b0;
      skid_data_q <= '0;
      skid_tag_q  <= '0;
      skid_err_q  <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            out_data_q  <= ext_data_d;
            out_tag_q   <= pipe.in_tag;
            out_err_q   <= ext_err_d;
            out_valid_q <= 1'b1;
            state_q     <= ONE;
          end
        end
        ONE: begin
          if (accept && take) begin
            out_data_q <= ext_data_d;
            out_tag_q  <= pipe.in_tag;
            out_err_q  <= ext_err_d;
          end else if (accept) begin
            // Output held by downstream: park the new beat and stop accepting.
            skid_data_q <= ext_data_d;
            skid_tag_q  <= pipe.in_tag;
            skid_err_q  <= ext_err_d;
            in_ready_q  <= 1'b0;
            state_q     <= FULL;
          end else if (take) begin
            out_valid_q <= 1'b0;
            state_q     <= EMPTY;
          end
        end
        FULL: begin
          if (take) begin
            out_data_q <= skid_data_q;
            out_tag_q  <= skid_tag_q;
            out_err_q  <= skid_err_q;
            in_ready_q <= 1'b1;
            state_q    <= ONE;
          end
        end
        default: begin
          state_q     <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign pipe.in_ready  = in_ready_q;
  assign pipe.out_valid = out_valid_q;
  assign pipe.out_data  = out_data_q;
  assign pipe.out_tag   = out_tag_q;
  assign pipe.out_err   = out_err_q;
endmodule
